// File: rtl/ddr4_cmd_timing_monitor_pkg.sv
// Shared DDR4 command encodings, violation bit positions and default timing values
// for the command timing monitor.
package ddr_pkg;

    typedef enum logic [1:0] {
        NOP = 2'd0,
        ACT = 2'd1,
        RD  = 2'd2,
        WR  = 2'd3
    } cmd_e;

    localparam int VIOL_CCD_S = 0;
    localparam int VIOL_CCD_L = 1;
    localparam int VIOL_RRD_S = 2;
    localparam int VIOL_RRD_L = 3;
    localparam int VIOL_FAW   = 4;
    localparam int VIOL_W     = 5;

    localparam int T_CCD_S_DEF = 4;
    localparam int T_CCD_L_DEF = 6;
    localparam int T_RRD_S_DEF = 4;
    localparam int T_RRD_L_DEF = 6;
    localparam int T_FAW_DEF   = 16;

    function automatic int max2(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/ddr4_cmd_timing_monitor_if.sv
// Command bus observed by the timing monitor plus its violation report signals.
interface ddr4_cmd_timing_monitor_if #(
    parameter int BG_W  = 2,
    parameter int BA_W  = 2,
    parameter int CNT_W = 16
) ();
    import ddr_pkg::*;

    logic              cmd_valid;
    cmd_e              cmd;
    logic [BG_W-1:0]   cmd_bg;
    logic [BA_W-1:0]   cmd_ba;
    logic              err_clr;

    logic              viol_valid;
    logic [VIOL_W-1:0] viol_flags;
    logic [VIOL_W-1:0] err_sticky;
    logic [CNT_W-1:0]  viol_count;

    modport master (
        output cmd_valid, cmd, cmd_bg, cmd_ba, err_clr,
        input  viol_valid, viol_flags, err_sticky, viol_count
    );

    modport slave (
        input  cmd_valid, cmd, cmd_bg, cmd_ba, err_clr,
        output viol_valid, viol_flags, err_sticky, viol_count
    );

endinterface

// File: rtl/ddr4_faw_window.sv
// Four-activate window tracker: ages of the last four ACTs in a shift queue
// (entry 3 is the oldest once four are held); faw_hit is combinational.
module ddr4_faw_window #(
    parameter int T_FAW = 16
) (
    input  logic clock_t,
    input  logic reset_n,
    input  logic act_push,
    output logic faw_hit
);
    localparam int AW = $clog2(T_FAW + 1);
    localparam logic [AW-1:0] AGE_SAT = AW'(T_FAW);
    localparam logic [AW-1:0] AGE_ONE = AW'(1);

    logic [AW-1:0] age_q [4];
    logic [AW-1:0] age_d [4];
    logic [2:0]    cnt_q;
    logic [2:0]    cnt_d;

    function automatic logic [AW-1:0] age_inc(input logic [AW-1:0] a);
        return (a == AGE_SAT) ? a : a + AGE_ONE;
    endfunction

    assign faw_hit = (cnt_q == 3'd4) && (age_q[3] < AGE_SAT);

    always_comb begin
        cnt_d = cnt_q;
        for (int i = 0; i < 4; i++) begin
            age_d[i] = age_inc(age_q[i]);
        end
        if (act_push) begin
            age_d[0] = AGE_ONE;
            for (int i = 1; i < 4; i++) begin
                age_d[i] = age_inc(age_q[i-1]);
            end
            cnt_d = (cnt_q == 3'd4) ? cnt_q : cnt_q + 3'd1;
        end
    end

    always_ff @(posedge clock_t or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < 4; i++) begin
                age_q[i] <= AGE_SAT;
            end
            cnt_q <= 3'd0;
        end else begin
            for (int i = 0; i < 4; i++) begin
                age_q[i] <= age_d[i];
            end
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/ddr4_cmd_timing_monitor.sv
// DDR4 command-bus monitor for tCCD_S/L, tRRD_S/L and tFAW spacing violations.
// The tFAW tracker is built only when DDR4_TFAW_CHECK_EN is defined.
module ddr4_cmd_timing_monitor
    import ddr_pkg::*;
#(
    parameter int BG_COUNT     = 4,
    parameter int BANKS_PER_BG = 4,
    parameter int T_CCD_S      = T_CCD_S_DEF,
    parameter int T_CCD_L      = T_CCD_L_DEF,
    parameter int T_RRD_S      = T_RRD_S_DEF,
    parameter int T_RRD_L      = T_RRD_L_DEF,
    parameter int T_FAW        = T_FAW_DEF,
    parameter int CNT_W        = 16
) (
    input logic                       clock_t,
    input logic                       reset_n,
    ddr4_cmd_timing_monitor_if.slave  bus
);
    localparam int BG_W    = (BG_COUNT > 1) ? $clog2(BG_COUNT) : 1;
    localparam int BA_W    = (BANKS_PER_BG > 1) ? $clog2(BANKS_PER_BG) : 1;
    localparam int AGE_MAX = max2(max2(max2(T_CCD_S, T_CCD_L), max2(T_RRD_S, T_RRD_L)), T_FAW);
    localparam int AGE_W   = $clog2(AGE_MAX + 1);

    localparam logic [AGE_W-1:0] AGE_SAT   = AGE_W'(AGE_MAX);
    localparam logic [AGE_W-1:0] AGE_ONE   = AGE_W'(1);
    localparam logic [AGE_W-1:0] LIM_CCD_S = AGE_W'(T_CCD_S);
    localparam logic [AGE_W-1:0] LIM_CCD_L = AGE_W'(T_CCD_L);
    localparam logic [AGE_W-1:0] LIM_RRD_S = AGE_W'(T_RRD_S);
    localparam logic [AGE_W-1:0] LIM_RRD_L = AGE_W'(T_RRD_L);
    localparam logic [CNT_W-1:0] CNT_MAX   = '1;

    logic [AGE_W-1:0]  cas_age_bg_q [BG_COUNT];
    logic [AGE_W-1:0]  cas_age_bg_d [BG_COUNT];
    logic [AGE_W-1:0]  act_age_bg_q [BG_COUNT];
    logic [AGE_W-1:0]  act_age_bg_d [BG_COUNT];
    logic [AGE_W-1:0]  cas_age_q, cas_age_d;
    logic [AGE_W-1:0]  act_age_q, act_age_d;

    logic              viol_valid_q, viol_valid_d;
    logic [VIOL_W-1:0] viol_flags_q, viol_flags_d;
    logic [VIOL_W-1:0] err_sticky_q, err_sticky_d;
    logic [CNT_W-1:0]  viol_count_q, viol_count_d;

    logic              is_cas;
    logic              is_act;
    logic              faw_hit;
    logic [AGE_W-1:0]  sel_cas_age;
    logic [AGE_W-1:0]  sel_act_age;
    logic [CNT_W-1:0]  count_base;
    logic [BA_W-1:0]   unused_ba;

    assign unused_ba = bus.cmd_ba;
    assign is_cas    = bus.cmd_valid && ((bus.cmd == RD) || (bus.cmd == WR));
    assign is_act    = bus.cmd_valid && (bus.cmd == ACT);

`ifdef DDR4_TFAW_CHECK_EN
    ddr4_faw_window #(.T_FAW(T_FAW)) u_faw_window (
        .clock_t  (clock_t),
        .reset_n  (reset_n),
        .act_push (is_act),
        .faw_hit  (faw_hit)
    );
`else
    assign faw_hit = 1'b0;
`endif

    function automatic logic [AGE_W-1:0] age_inc(input logic [AGE_W-1:0] a);
        return (a == AGE_SAT) ? a : a + AGE_ONE;
    endfunction

    always_comb begin
        sel_cas_age = AGE_SAT;
        sel_act_age = AGE_SAT;
        for (int i = 0; i < BG_COUNT; i++) begin
            cas_age_bg_d[i] = age_inc(cas_age_bg_q[i]);
            act_age_bg_d[i] = age_inc(act_age_bg_q[i]);
            if (bus.cmd_bg == BG_W'(i)) begin
                sel_cas_age = cas_age_bg_q[i];
                sel_act_age = act_age_bg_q[i];
                if (is_cas) cas_age_bg_d[i] = AGE_ONE;
                if (is_act) act_age_bg_d[i] = AGE_ONE;
            end
        end
        cas_age_d = is_cas ? AGE_ONE : age_inc(cas_age_q);
        act_age_d = is_act ? AGE_ONE : age_inc(act_age_q);

        // Short-spacing flags are suppressed when the same-group flag already fires.
        viol_flags_d             = '0;
        viol_flags_d[VIOL_CCD_L] = is_cas && (sel_cas_age < LIM_CCD_L);
        viol_flags_d[VIOL_CCD_S] = is_cas && !viol_flags_d[VIOL_CCD_L] && (cas_age_q < LIM_CCD_S);
        viol_flags_d[VIOL_RRD_L] = is_act && (sel_act_age < LIM_RRD_L);
        viol_flags_d[VIOL_RRD_S] = is_act && !viol_flags_d[VIOL_RRD_L] && (act_age_q < LIM_RRD_S);
        viol_flags_d[VIOL_FAW]   = is_act && faw_hit;
        viol_valid_d             = |viol_flags_d;

        // Clear takes effect before the same-cycle violation is accounted.
        err_sticky_d = (bus.err_clr ? '0 : err_sticky_q) | viol_flags_d;
        count_base   = bus.err_clr ? '0 : viol_count_q;
        viol_count_d = (viol_valid_d && (count_base != CNT_MAX)) ? count_base + 1'b1 : count_base;
    end

    always_ff @(posedge clock_t or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < BG_COUNT; i++) begin
                cas_age_bg_q[i] <= AGE_SAT;
                act_age_bg_q[i] <= AGE_SAT;
            end
            cas_age_q    <= AGE_SAT;
            act_age_q    <= AGE_SAT;
            viol_valid_q <= 1'b0;
            viol_flags_q <= '0;
            err_sticky_q <= '0;
            viol_count_q <= '0;
        end else begin
            for (int i = 0; i < BG_COUNT; i++) begin
                cas_age_bg_q[i] <= cas_age_bg_d[i];
                act_age_bg_q[i] <= act_age_bg_d[i];
            end
            cas_age_q    <= cas_age_d;
            act_age_q    <= act_age_d;
            viol_valid_q <= viol_valid_d;
            viol_flags_q <= viol_flags_d;
            err_sticky_q <= err_sticky_d;
            viol_count_q <= viol_count_d;
        end
    end

    assign bus.viol_valid = viol_valid_q;
    assign bus.viol_flags = viol_flags_q;
    assign bus.err_sticky = err_sticky_q;
    assign bus.viol_count = viol_count_q;

endmodule
